// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Single-channel APB requester. A 2-bit command strobe launches one complete
// APB transfer to a fixed peripheral register:
//   - read  (transfer = 2'b01): fetch a byte into the internal read register
//   - write (transfer = 2'b11): store (last read byte + 1) back to the register
//
// Ports
//   pclk        in   clock, rising-edge active
//   preset_n    in   asynchronous active-low reset
//   transfer    in   [1:0] command, sampled only in IDLE
//   prdata_i    in   [7:0] completer read data, sampled on read completion
//   pready_i    in   completer ready, observed only in ACCESS
//   psel_o      out  APB select
//   penable_o   out  APB enable
//   paddr_o     out  [7:0] APB address (RW_ADDR while busy)
//   pwrite_o    out  APB direction, 1 = write
//   pwdata_o    out  [7:0] APB write data
// -----------------------------------------------------------------------------
module apb_master #(
  parameter logic [7:0] RW_ADDR = 8'hA0
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic [1:0] transfer,
  input  logic [7:0] prdata_i,
  input  logic       pready_i,
  output logic       psel_o,
  output logic       penable_o,
  output logic [7:0] paddr_o,
  output logic       pwrite_o,
  output logic [7:0] pwdata_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic       r_cmd_write;
  logic       w_cmd_write_next;
  logic [7:0] r_rdata;
  logic [7:0] w_rdata_next;

  // transfer[0] distinguishes a real command (01/11) from a no-op (00/10).
  logic w_start;
  logic w_done;

  assign w_start = (r_state == StIdle) && transfer[0];
  assign w_done  = (r_state == StAccess) && pready_i;

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state     <= StIdle;
      r_cmd_write <= 1'b0;
      r_rdata     <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_cmd_write <= w_cmd_write_next;
      r_rdata     <= w_rdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_cmd_write_next = r_cmd_write;
    w_rdata_next     = r_rdata;

    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next     = StSetup;
          w_cmd_write_next = transfer[1];
        end
      end
      StSetup: begin
        w_state_next = StAccess;
      end
      StAccess: begin
        // No timeout: a completer that never answers holds the bus forever.
        if (w_done) begin
          w_state_next = StIdle;
          if (!r_cmd_write) begin
            w_rdata_next = prdata_i;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. Driven purely from registers so an asynchronous reset
  // clears the bus immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  logic w_busy;
  assign w_busy = (r_state == StSetup) || (r_state == StAccess);

  always_comb begin
    psel_o    = 1'b0;
    penable_o = 1'b0;
    paddr_o   = 8'h00;
    pwrite_o  = 1'b0;
    pwdata_o  = 8'h00;

    if (w_busy) begin
      psel_o    = 1'b1;
      penable_o = (r_state == StAccess);
      paddr_o   = RW_ADDR;
      pwrite_o  = r_cmd_write;
      // Increment wraps naturally at 8 bits (FF -> 00).
      pwdata_o  = r_cmd_write ? (r_rdata + 8'd1) : 8'h00;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  localparam logic [7:0] Addr = 8'hA0;

  logic       pclk;
  logic       preset_n;
  logic [1:0] transfer;
  logic [7:0] prdata_i;
  logic       pready_i;
  logic       psel_o;
  logic       penable_o;
  logic [7:0] paddr_o;
  logic       pwrite_o;
  logic [7:0] pwdata_o;

  apb_master #(
    .RW_ADDR (Addr)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .transfer  (transfer),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .paddr_o   (paddr_o),
    .pwrite_o  (pwrite_o),
    .pwdata_o  (pwdata_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Observed bus: {psel, penable, paddr[7:0], pwrite, pwdata[7:0]}
  logic [18:0] obs;
  assign obs = {psel_o, penable_o, paddr_o, pwrite_o, pwdata_o};

  typedef struct packed {
    logic [1:0] tr;
    logic       rdy;
    logic [7:0] rd;
  } stim_t;

  stim_t       stim_q[$];
  logic [18:0] exp_q[$];
  logic [7:0]  m_rdata;  // reference model of the read register
  int          n_chk;
  int          n_pass;

  // Expected bus value for a cycle; write data derives from the model.
  function automatic logic [18:0] bus(input logic sel, input logic en, input logic wr);
    logic [7:0] a;
    logic [7:0] d;
    a = sel ? Addr : 8'h00;
    d = (sel && wr) ? (m_rdata + 8'd1) : 8'h00;
    return {sel, en, a, wr, d};
  endfunction

  task automatic push(input logic [1:0] tr, input logic rdy, input logic [7:0] rd,
                      input logic [18:0] e);
    stim_t s;
    s.tr  = tr;
    s.rdy = rdy;
    s.rd  = rd;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Drive queued stimulus one edge at a time; compare the scoreboard after each.
  task automatic run(input string name);
    stim_t       s;
    logic [18:0] e;
    int          cyc;
    cyc = 0;
    while (stim_q.size() > 0) begin
      s        = stim_q.pop_front();
      transfer = s.tr;
      pready_i = s.rdy;
      prdata_i = s.rd;
      @(posedge pclk);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) $display("FAIL %s cyc %0d: bus got %h expected %h", name, cyc, obs, e);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    transfer = 2'b01;
    pready_i = 1'b0;
    prdata_i = 8'h00;
    m_rdata  = 8'h00;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs !== 19'h0) $display("FAIL reset step %0d: bus got %h expected 0", i, obs);
      else n_pass++;
      if (i < 2) begin
        @(posedge pclk);
        #1;
      end
    end
    n_chk++;
    if (dut.r_rdata !== 8'h00) $display("FAIL reset rdata: got %h expected 00", dut.r_rdata);
    else n_pass++;
    preset_n = 1'b1;
    // After release, an idle command keeps the bus quiet.
    push(2'b00, 1'b0, 8'h00, bus(1'b0, 1'b0, 1'b0));
    push(2'b00, 1'b0, 8'h00, bus(1'b0, 1'b0, 1'b0));
    run("reset_release");
  endtask

  // Read with one wait state in ACCESS (2-cycle ACCESS).
  task automatic test_read(input string name, input logic [7:0] data);
    push(2'b01, 1'b0, 8'h5A, bus(1'b1, 1'b0, 1'b0));
    push(2'b00, 1'b0, 8'h5A, bus(1'b1, 1'b1, 1'b0));
    push(2'b00, 1'b0, 8'hC3, bus(1'b1, 1'b1, 1'b0));
    push(2'b00, 1'b1, data,  bus(1'b0, 1'b0, 1'b0));
    run(name);
    m_rdata = data;
    n_chk++;
    if (dut.r_rdata !== m_rdata) $display("FAIL %s rdata: got %h expected %h", name, dut.r_rdata, m_rdata);
    else n_pass++;
  endtask

  // Write with pready already high; pready during SETUP must be ignored.
  task automatic test_write(input string name);
    push(2'b11, 1'b1, 8'h33, bus(1'b1, 1'b0, 1'b1));
    push(2'b00, 1'b1, 8'h33, bus(1'b1, 1'b1, 1'b1));
    push(2'b00, 1'b1, 8'h33, bus(1'b0, 1'b0, 1'b0));
    push(2'b00, 1'b1, 8'h33, bus(1'b0, 1'b0, 1'b0));
    run(name);
    n_chk++;
    if (dut.r_rdata !== m_rdata) $display("FAIL %s rdata: got %h expected %h", name, dut.r_rdata, m_rdata);
    else n_pass++;
  endtask

  task automatic test_ignored_idle();
    for (int i = 0; i < 3; i++) push(2'b10, 1'b1, 8'h77, bus(1'b0, 1'b0, 1'b0));
    run("ignored_10");
  endtask

  task automatic test_cmd_during_access();
    push(2'b01, 1'b0, 8'h00, bus(1'b1, 1'b0, 1'b0));
    push(2'b11, 1'b0, 8'h00, bus(1'b1, 1'b1, 1'b0));
    push(2'b11, 1'b1, 8'h42, bus(1'b0, 1'b0, 1'b0));
    push(2'b00, 1'b0, 8'h00, bus(1'b0, 1'b0, 1'b0));
    push(2'b00, 1'b0, 8'h00, bus(1'b0, 1'b0, 1'b0));
    run("busy_cmd_dropped");
    m_rdata = 8'h42;
  endtask

  task automatic test_wait_states();
    push(2'b01, 1'b0, 8'h00, bus(1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) push(2'b00, 1'b0, 8'hEE, bus(1'b1, 1'b1, 1'b0));
    push(2'b00, 1'b1, 8'h10, bus(1'b0, 1'b0, 1'b0));
    run("wait_states");
    m_rdata = 8'h10;
    n_chk++;
    if (dut.r_rdata !== m_rdata) $display("FAIL wait_states rdata: got %h expected %h", dut.r_rdata, m_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    push(2'b01, 1'b0, 8'h00, bus(1'b1, 1'b0, 1'b0));
    push(2'b00, 1'b0, 8'h00, bus(1'b1, 1'b1, 1'b0));
    run("pre_reset");
    preset_n = 1'b0;
    m_rdata  = 8'h00;
    #1;  // well away from any clock edge
    n_chk++;
    if (obs !== 19'h0) $display("FAIL async_reset bus: got %h expected 0", obs);
    else n_pass++;
    n_chk++;
    if (dut.r_rdata !== m_rdata) $display("FAIL async_reset rdata: got %h expected %h", dut.r_rdata, m_rdata);
    else n_pass++;
    @(posedge pclk);
    #1;
    preset_n = 1'b1;
    transfer = 2'b00;
    pready_i = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_read("read_05", 8'h05);
    test_write("write_06");
    test_read("read_ff", 8'hFF);
    test_write("write_wrap_00");
    test_ignored_idle();
    test_cmd_during_access();
    test_write("write_43");
    test_wait_states();
    test_reset_mid_access();
    test_write("write_01_after_reset");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
